// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : controller state encoding
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the serial adder's per-bit arithmetic cell.
// Ports:
//   a, b, cin : operand bits and carry-in
//   sum       : a ^ b ^ cin
//   carry     : carry-out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first,
// through a single full adder with a registered carry.
// Ports:
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_start : request an addition (accepted in IDLE or DONE)
//   i_a/i_b : operands, i_cin : carry-in (captured on acceptance)
//   o_busy  : high while bits are being processed
//   o_done  : one-cycle pulse when o_sum/o_cout hold a new result
//   o_sum   : registered result, o_cout : registered carry-out
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | waiting for i_start
// ST_SHIFT | processing one operand bit per clock
// ST_DONE  | result valid; o_done high, may accept a new start
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_psum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_sum_bit;
   logic             w_carry_out;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_psum_next;

   full_adder u_fa (
      .a     (r_a[0]),
      .b     (r_b[0]),
      .cin   (r_carry),
      .sum   (w_sum_bit),
      .carry (w_carry_out)
   );

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 of the
   // result sits at bit 0 of the register.
   assign w_psum_next = (r_psum >> 1) | (WIDTH'(w_sum_bit) << (WIDTH - 1));

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_accept     = 1'b1;
               w_next_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            o_busy = 1'b1;
            if (w_last) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            o_done = 1'b1;
            if (i_start) begin
               w_accept     = 1'b1;
               w_next_state = ST_SHIFT;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_psum  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         o_sum   <= '0;
         o_cout  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_cin;
            r_psum  <= '0;
            r_cnt   <= '0;
         end else if (r_state == ST_SHIFT) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_carry_out;
            r_psum  <= w_psum_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
               o_sum  <= w_psum_next;
               o_cout <= w_carry_out;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   int n_pass  = 0;
   int n_total = 0;

   serial_adder #(.WIDTH(8)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_a     (a),
      .i_b     (b),
      .i_cin   (cin),
      .o_busy  (busy),
      .o_done  (done),
      .o_sum   (sum),
      .o_cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Precondition: at a negedge with the DUT idle. Leaves the bench at the
   // negedge after the done cycle, DUT idle again.
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tc);
      logic [8:0] exp;
      logic [7:0] prev_sum;
      logic       prev_cout;
      logic       stable;
      int         cyc;
      int         nbusy;
      exp       = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
      prev_sum  = sum;
      prev_cout = cout;
      start = 1'b1; a = ta; b = tb_; cin = tc;
      @(negedge clk);
      start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
      cyc = 1; nbusy = 0; stable = 1'b1;
      while (!done && cyc < 40) begin
         if (busy) nbusy++;
         if (sum !== prev_sum || cout !== prev_cout) stable = 1'b0;
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'd9);
      chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
      chk({tag, "_hold"}, 32'(stable), 32'd1);
      chk({tag, "_sum"}, 32'(sum), 32'(exp[7:0]));
      chk({tag, "_cout"}, 32'(cout), 32'(exp[8]));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int         cyc;
      int         t;
      int         last_done;
      int         ndone;
      logic       flag;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      rst = 1'b0;

      run_op("zero", 8'h00, 8'h00, 1'b0);
      run_op("ff_01", 8'hFF, 8'h01, 1'b0);
      run_op("a5_5a", 8'hA5, 8'h5A, 1'b1);

      // start pulsed mid-operation must be ignored
      start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc < 3) begin @(negedge clk); cyc++; end
      start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      @(negedge clk); cyc++;
      start = 1'b0;
      while (!done && cyc < 40) begin @(negedge clk); cyc++; end
      chk("ignore_latency", 32'(cyc), 32'd9);
      chk("ignore_sum", 32'(sum), 32'h30);
      chk("ignore_cout", 32'(cout), 32'd0);
      @(negedge clk);
      chk("ignore_idle_busy", 32'(busy), 32'd0);
      flag = 1'b0;
      repeat (12) begin @(negedge clk); if (done) flag = 1'b1; end
      chk("ignore_no_second", 32'(flag), 32'd0);

      // reset in the middle of an operation aborts it
      start = 1'b1; a = 8'h55; b = 8'h33; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      flag = 1'b0;
      repeat (12) begin @(negedge clk); if (done || busy) flag = 1'b1; end
      chk("abort_quiet", 32'(flag), 32'd0);
      run_op("after_rst", 8'h7F, 8'h01, 1'b0);

      // start held high: back-to-back results every 9 cycles
      start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
      t = 0; last_done = 0; ndone = 0; flag = 1'b0;
      while (t < 30) begin
         @(negedge clk);
         t++;
         if (ndone > 0 && sum !== 8'h03) flag = 1'b1;
         if (done) begin
            ndone++;
            chk("b2b_interval", 32'(t - last_done), 32'd9);
            chk("b2b_sum", 32'(sum), 32'h03);
            last_done = t;
         end
      end
      chk("b2b_count", 32'(ndone), 32'd3);
      chk("b2b_stable", 32'(flag), 32'd0);
      start = 1'b0;
      repeat (12) @(negedge clk);

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         run_op("rand", ra, rb, rc);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
